// File: rtl/text_writer.sv
// text_writer: producer side of the character text RAM.
// Consumes a byte stream (valid/ready), interprets CR/LF/BS/FF, writes
// {attr,char} cells, and tracks the cursor and hardware-scroll top row.
// Line and screen clears are sequenced one word per cycle with in_ready low.
module text_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_char,
  input  logic [7:0]                in_attr,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [15:0]               ram_data,
  output logic                      ram_wren,
  output logic [$clog2(COLS)-1:0]   cursor_x,
  output logic [$clog2(ROWS)-1:0]   cursor_y,
  output logic [$clog2(ROWS)-1:0]   top_row,
  output logic                      busy
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  // One spare bit so the counter can reach COLS*ROWS even when it fills ADDR_W.
  localparam int CW = ADDR_W + 1;

  localparam logic [XW-1:0]     X_LAST    = XW'(COLS - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(ROWS - 1);
  localparam logic [YW:0]       ROWS_W    = (YW + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [CW-1:0]     COLS_CNT  = CW'(COLS);
  localparam logic [CW-1:0]     TOTAL_CNT = CW'(COLS * ROWS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_LINE   = 2'd1,
    CLEAR_SCREEN = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [XW-1:0]       x_reg, x_next;
  logic [YW-1:0]       y_reg, y_next;
  logic [YW-1:0]       top_reg, top_next;
  logic [7:0]          clr_reg, clr_next;
  logic                ready_reg, ready_next;
  logic                wren_reg, wren_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [15:0]         data_reg, data_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [CW-1:0]       cnt_reg, cnt_next;

  logic [YW:0]         row_sum;
  logic [YW:0]         row_phys;
  logic [ADDR_W-1:0]   cell_addr;
  logic [ADDR_W-1:0]   top_base;
  logic [YW-1:0]       top_inc;
  logic                printable;

  // Physical address of the cursor cell and of the current top row; the
  // row wrap is a single compare/subtract since y+top < 2*ROWS.
  always_comb begin
    row_sum   = {1'b0, y_reg} + {1'b0, top_reg};
    row_phys  = (row_sum >= ROWS_W) ? (row_sum - ROWS_W) : row_sum;
    cell_addr = ADDR_W'(row_phys) * COLS_A + ADDR_W'(x_reg);
    top_base  = ADDR_W'(top_reg) * COLS_A;
    top_inc   = (top_reg == Y_LAST) ? '0 : top_reg + 1'b1;
    printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  end

  // Next-state and registered-output logic for the command/clear FSM.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    top_next   = top_reg;
    clr_next   = clr_reg;
    wren_next  = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    base_next  = base_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (printable) begin
            wren_next = 1'b1;
            addr_next = cell_addr;
            data_next = {in_attr, in_char};
            clr_next  = in_attr;
            if (x_reg == X_LAST) begin
              x_next = '0;
              if (y_reg != Y_LAST) begin
                y_next = y_reg + 1'b1;
              end else begin
                // Wrap-scroll: this cycle carries the char write, the
                // old top row is cleared starting next cycle.
                top_next   = top_inc;
                base_next  = top_base;
                cnt_next   = '0;
                state_next = CLEAR_LINE;
              end
            end else begin
              x_next = x_reg + 1'b1;
            end
          end else if (in_char == CH_CR) begin
            x_next = '0;
          end else if (in_char == CH_LF) begin
            if (y_reg != Y_LAST) begin
              y_next = y_reg + 1'b1;
            end else begin
              // LF-scroll: first blank word goes out right away.
              top_next   = top_inc;
              base_next  = top_base;
              wren_next  = 1'b1;
              addr_next  = top_base;
              data_next  = {clr_reg, BLANK};
              cnt_next   = CW'(1);
              state_next = CLEAR_LINE;
            end
          end else if (in_char == CH_BS) begin
            if (x_reg != '0) begin
              x_next = x_reg - 1'b1;
            end
          end else if (in_char == CH_FF) begin
            x_next     = '0;
            y_next     = '0;
            top_next   = '0;
            wren_next  = 1'b1;
            addr_next  = '0;
            data_next  = {clr_reg, BLANK};
            cnt_next   = CW'(1);
            state_next = CLEAR_SCREEN;
          end
        end
      end

      CLEAR_LINE: begin
        if (cnt_reg == COLS_CNT) begin
          state_next = IDLE;
        end else begin
          wren_next = 1'b1;
          addr_next = base_reg + cnt_reg[ADDR_W-1:0];
          data_next = {clr_reg, BLANK};
          cnt_next  = cnt_reg + 1'b1;
        end
      end

      CLEAR_SCREEN: begin
        if (cnt_reg == TOTAL_CNT) begin
          state_next = IDLE;
        end else begin
          wren_next = 1'b1;
          addr_next = cnt_reg[ADDR_W-1:0];
          data_next = {clr_reg, BLANK};
          cnt_next  = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
  end

  // State and output registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      top_reg   <= '0;
      clr_reg   <= 8'h07;
      ready_reg <= 1'b1;
      wren_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      base_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      top_reg   <= top_next;
      clr_reg   <= clr_next;
      ready_reg <= ready_next;
      wren_reg  <= wren_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      base_reg  <= base_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign in_ready = ready_reg;
  assign busy     = ~ready_reg;
  assign ram_wren = wren_reg;
  assign ram_addr = addr_reg;
  assign ram_data = data_reg;
  assign cursor_x = x_reg;
  assign cursor_y = y_reg;
  assign top_row  = top_reg;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: printable writes, CR/LF/BS/FF, scroll
// line clears, full-screen clear and reset in the middle of a clear.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  top_row;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [11:0] qa[$];
  logic [15:0] qd[$];

  text_writer #(.COLS(80), .ROWS(30), .ADDR_W(12), .BLANK(8'h20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .top_row(top_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Log every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      qa.push_back(ram_addr);
      qd.push_back(ram_data);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    qa.delete();
    qd.delete();
  endtask

  // Counts cycles until in_ready is high again (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Present one byte; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    wait_ready(n);
    if (n >= 5000) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1");
    end
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int drops;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_xy", {cursor_x, 3'b0, cursor_y}, 0);
    chk("rst_top", top_row, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ---- single printable
    clear_log();
    send(8'h41, 8'h1F);
    chk("A_wren", ram_wren, 1);
    chk("A_addr", ram_addr, 12'd0);
    chk("A_data", ram_data, 16'h1F41);
    chk("A_x", cursor_x, 1);
    chk("A_y", cursor_y, 0);
    chk("A_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("A_wren_drop", ram_wren, 0);
    $display("[TB] txn 'A': addr=%0d data=%h", qa.size() ? qa[0] : 12'd0, qd.size() ? qd[0] : 16'd0);

    // ---- 80 back-to-back printables on row 0
    send(8'h0D, 8'h00);
    chk("CR_x", cursor_x, 0);
    clear_log();
    drops = 0;
    for (int i = 0; i < 80; i++) begin
      send(8'h21 + 8'(i), 8'h07);
      if (in_ready !== 1'b1) drops++;
    end
    @(posedge clk); #1;
    chk("row_ready_drops", drops, 0);
    chk("row_nwrites", qa.size(), 80);
    bad = 0;
    for (int i = 0; i < qa.size() && i < 80; i++)
      if (qa[i] !== 12'(i) || qd[i] !== {8'h07, 8'h21 + 8'(i)}) bad++;
    chk("row_seq", bad, 0);
    chk("row_x", cursor_x, 0);
    chk("row_y", cursor_y, 1);
    $display("[TB] txn row0: %0d writes", qa.size());

    // ---- LFs down to the last row, then a scrolling LF
    clear_log();
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    chk("lf_y", cursor_y, 29);
    chk("lf_nowrite", qa.size(), 0);
    chk("lf_top", top_row, 0);
    send(8'h0A, 8'h00);
    chk("scroll_ready_low", in_ready, 0);
    chk("scroll_busy", busy, 1);
    chk("scroll_top", top_row, 1);
    wait_ready(n);
    chk("scroll_low_cycles", n, 80);
    chk("scroll_nwrites", qa.size(), 80);
    bad = 0;
    for (int i = 0; i < qa.size() && i < 80; i++)
      if (qa[i] !== 12'(i) || qd[i] !== 16'h0720) bad++;
    chk("scroll_clear", bad, 0);
    chk("scroll_y", cursor_y, 29);
    $display("[TB] txn LF-scroll: low=%0d writes=%0d top=%0d", n, qa.size(), top_row);
    clear_log();
    send(8'h42, 8'h1E);
    chk("B_addr", ram_addr, 12'd0);
    chk("B_data", ram_data, 16'h1E42);
    chk("B_x", cursor_x, 1);

    // ---- BS / CR / ignored codes
    send(8'h0D, 8'h00);
    @(posedge clk); #1;
    clear_log();
    send(8'h08, 8'h00);
    chk("BS_at0", cursor_x, 0);
    for (int i = 0; i < 5; i++) send(8'h61, 8'h07);
    chk("five_x", cursor_x, 5);
    @(posedge clk); #1;
    clear_log();
    send(8'h08, 8'h00);
    chk("BS_at5", cursor_x, 4);
    send(8'h0D, 8'h00);
    chk("CR_at4", cursor_x, 0);
    send(8'h01, 8'h55);
    chk("ign_xy", {cursor_x, 3'b0, cursor_y}, {7'd0, 3'b0, 5'd29});
    @(posedge clk); #1;
    chk("ctl_nowrite", qa.size(), 0);
    $display("[TB] txn BS/CR: x=%0d writes=%0d", cursor_x, qa.size());

    // ---- wrap on the last row: char write then clear of old top row 1
    for (int i = 0; i < 79; i++) send(8'h30, 8'h2A);
    chk("pre_wrap_x", cursor_x, 79);
    @(posedge clk); #1;
    clear_log();
    send(8'h5A, 8'h3C);
    chk("wrap_addr", ram_addr, 12'd79);
    chk("wrap_data", ram_data, 16'h3C5A);
    chk("wrap_top", top_row, 2);
    wait_ready(n);
    chk("wrap_low_cycles", n, 81);
    chk("wrap_nwrites", qa.size(), 81);
    bad = 0;
    for (int i = 1; i < qa.size() && i < 81; i++)
      if (qa[i] !== 12'(79 + i) || qd[i] !== 16'h3C20) bad++;
    chk("wrap_clear", bad, 0);
    chk("wrap_xy", {cursor_x, 3'b0, cursor_y}, {7'd0, 3'b0, 5'd29});
    $display("[TB] txn wrap-scroll: low=%0d writes=%0d top=%0d", n, qa.size(), top_row);

    // ---- full screen clear
    clear_log();
    send(8'h0C, 8'h00);
    chk("ff_top", top_row, 0);
    chk("ff_xy", {cursor_x, 3'b0, cursor_y}, 0);
    wait_ready(n);
    chk("ff_low_cycles", n, 2400);
    chk("ff_nwrites", qa.size(), 2400);
    bad = 0;
    for (int i = 0; i < qa.size() && i < 2400; i++)
      if (qa[i] !== 12'(i) || qd[i] !== 16'h3C20) bad++;
    chk("ff_clear", bad, 0);
    @(posedge clk); #1;
    chk("ff_wren_drop", ram_wren, 0);
    $display("[TB] txn FF: low=%0d writes=%0d", n, qa.size());

    // ---- reset in the middle of a screen clear
    send(8'h41, 8'h5B);
    send(8'h0C, 8'h00);
    repeat (1000) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_wren", ram_wren, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_log();
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_nowrite", qa.size(), 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_xy", {cursor_x, 3'b0, cursor_y}, 0);
    chk("post_rst_top", top_row, 0);
    $display("[TB] txn reset-mid-FF: writes after release=%0d", qa.size());

    // ---- clear attribute returns to 0x07 after reset
    for (int i = 0; i < 29; i++) send(8'h0A, 8'h00);
    clear_log();
    send(8'h0A, 8'h00);
    wait_ready(n);
    chk("rst_clr_nwrites", qa.size(), 80);
    chk("rst_clr_data", qd.size() ? qd[0] : 16'h0, 16'h0720);
    $display("[TB] txn post-reset scroll: writes=%0d", qa.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
